// File: rtl/int_branch_resolve_unit_pkg.sv
// Shared types for the integer branch resolve unit: update-FIFO entry,
// recovery FSM states and the active-list age helper.
package int_branch_resolve_unit_pkg;

   localparam int PC_W    = 32;
   localparam int GHIST_W = 10;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [PC_W-1:0]    next;
      logic               taken;
      logic               is_cond;
      logic [GHIST_W-1:0] ghist;
   } br_update_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } br_resolve_state_e;

   // Distance from the active-list head; smaller means older.
   function automatic logic [15:0] age_of(input logic [15:0] ptr,
                                          input logic [15:0] head,
                                          input int          width);
      logic [15:0] mask;
      mask = 16'((32'd1 << width) - 32'd1);
      return (ptr - head) & mask;
   endfunction

endpackage

// File: rtl/int_branch_resolve_unit_if.sv
// Branch-result, recovery and predictor-update bus of the resolve unit.
// master = surrounding pipeline, slave = resolve unit.
interface int_branch_resolve_unit_if
   import int_branch_resolve_unit_pkg::*;
#(
   parameter int LANES    = 2,
   parameter int AL_PTR_W = 6
) ();

   logic [LANES-1:0]                  br_valid;
   logic [LANES-1:0]                  br_mispred;
   logic [LANES-1:0][AL_PTR_W-1:0]    br_al_ptr;
   logic [LANES-1:0][PC_W-1:0]        br_pc;
   logic [LANES-1:0][PC_W-1:0]        br_next;
   logic [LANES-1:0]                  br_taken;
   logic [LANES-1:0]                  br_is_cond;
   logic [LANES-1:0][GHIST_W-1:0]     br_ghist;
   logic [AL_PTR_W-1:0]               al_head;
   logic                              rec_valid;
   logic [AL_PTR_W-1:0]               rec_al_ptr;
   logic [PC_W-1:0]                   rec_target;
   logic                              rec_ack;
   logic                              rec_done;
   logic                              upd_valid;
   br_update_entry_t                  upd_entry;
   logic                              upd_ready;
   logic                              stall_req;

   modport master (
      output br_valid, br_mispred, br_al_ptr, br_pc, br_next, br_taken,
             br_is_cond, br_ghist, al_head, rec_ack, rec_done, upd_ready,
      input  rec_valid, rec_al_ptr, rec_target, upd_valid, upd_entry, stall_req
   );

   modport slave (
      input  br_valid, br_mispred, br_al_ptr, br_pc, br_next, br_taken,
             br_is_cond, br_ghist, al_head, rec_ack, rec_done, upd_ready,
      output rec_valid, rec_al_ptr, rec_target, upd_valid, upd_entry, stall_req
   );

endinterface

// File: rtl/int_branch_resolve_unit_fifo.sv
// Multi-push / single-pop FIFO feeding the predictor updater, plus its
// overflow checker. Lanes are written in index order after the tail.
module br_update_fifo_chk #(
   parameter int PTR_W = 4,
   parameter int DEPTH = 8
) (
   input logic             clk,
   input logic             rst_n,
   input logic [PTR_W-1:0] count_i,
   input logic [PTR_W-1:0] push_cnt_i
);
   localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);

   no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
      push_cnt_i <= DEPTH_C - count_i);
endmodule

module br_update_fifo #(
   parameter int  LANES   = 2,
   parameter int  DEPTH   = 8,
   parameter type entry_t = logic
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [LANES-1:0] push_i,
   input  entry_t           push_data_i [LANES],
   input  logic             pop_i,
   output logic             valid_o,
   output entry_t           data_o,
   output logic             stall_o
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam logic [PTR_W-1:0] THRESH = PTR_W'(DEPTH - LANES);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] count_s, count_d, push_cnt_s;
   logic [PTR_W-1:0] slot_s [LANES];
   logic             valid_q, stall_q, pop_s;

   // Each pushing lane lands after every lower-numbered pushing lane.
   always_comb begin
      push_cnt_s = '0;
      for (int l = 0; l < LANES; l++) begin
         slot_s[l] = wr_ptr_q + push_cnt_s;
         if (push_i[l]) push_cnt_s = push_cnt_s + PTR_W'(1);
         else           push_cnt_s = push_cnt_s;
      end
   end

   assign pop_s    = pop_i & valid_q;
   assign count_s  = wr_ptr_q - rd_ptr_q;
   assign count_d  = count_s + push_cnt_s - PTR_W'(pop_s);
   assign wr_ptr_d = wr_ptr_q + push_cnt_s;
   assign rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);

   // Pointers, storage and the registered valid/stall flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         valid_q  <= 1'b0;
         stall_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         valid_q  <= (count_d != '0);
         stall_q  <= (count_d > THRESH);
         for (int l = 0; l < LANES; l++) begin
            if (push_i[l]) mem_q[slot_s[l][IDX_W-1:0]] <= push_data_i[l];
         end
      end
   end

   assign valid_o = valid_q;
   assign data_o  = mem_q[rd_ptr_q[IDX_W-1:0]];
   assign stall_o = stall_q;

   br_update_fifo_chk #(.PTR_W(PTR_W), .DEPTH(DEPTH)) u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .count_i    (count_s),
      .push_cnt_i (push_cnt_s)
   );

endmodule

// File: rtl/int_branch_resolve_unit.sv
// Multi-lane branch resolution: oldest-mispredict select, recovery request
// FSM with one pending slot, and the predictor update FIFO.
module int_branch_resolve_unit
   import int_branch_resolve_unit_pkg::*;
#(
   parameter int LANES      = 2,
   parameter int AL_PTR_W   = 6,
   parameter int FIFO_DEPTH = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   int_branch_resolve_unit_if.slave bus
);

   function automatic logic [AL_PTR_W-1:0] age(input logic [AL_PTR_W-1:0] p,
                                               input logic [AL_PTR_W-1:0] h);
      return AL_PTR_W'(age_of(16'(p), 16'(h), AL_PTR_W));
   endfunction

   br_resolve_state_e   state_q;
   logic                rec_valid_q, pend_valid_q;
   logic [AL_PTR_W-1:0] req_ptr_q, pend_ptr_q;
   logic [PC_W-1:0]     req_tgt_q, pend_tgt_q;

   logic                sel_valid_s, sel_older_req_s, sel_keep_s;
   logic [AL_PTR_W-1:0] sel_ptr_s, sel_age_s;
   logic [PC_W-1:0]     sel_tgt_s;
   br_update_entry_t    push_data_s [LANES];
   logic                upd_valid_s, stall_s;
   br_update_entry_t    upd_entry_s;

   // Oldest mispredict across lanes; strict compare keeps the lowest lane on ties.
   always_comb begin
      sel_valid_s = 1'b0;
      sel_ptr_s   = '0;
      sel_age_s   = '0;
      sel_tgt_s   = '0;
      for (int l = 0; l < LANES; l++) begin
         if (bus.br_valid[l] && bus.br_mispred[l] &&
             (!sel_valid_s || (age(bus.br_al_ptr[l], bus.al_head) < sel_age_s))) begin
            sel_valid_s = 1'b1;
            sel_ptr_s   = bus.br_al_ptr[l];
            sel_age_s   = age(bus.br_al_ptr[l], bus.al_head);
            sel_tgt_s   = bus.br_next[l];
         end else begin
            sel_valid_s = sel_valid_s;
         end
      end
   end

   assign sel_older_req_s = sel_valid_s && (sel_age_s < age(req_ptr_q, bus.al_head));
   assign sel_keep_s      = sel_older_req_s &&
                            (!pend_valid_q || (sel_age_s < age(pend_ptr_q, bus.al_head)));

   // Recovery FSM; the held request is also the registered output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rec_valid_q  <= 1'b0;
         req_ptr_q    <= '0;
         req_tgt_q    <= '0;
         pend_valid_q <= 1'b0;
         pend_ptr_q   <= '0;
         pend_tgt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sel_valid_s) begin
                  req_ptr_q   <= sel_ptr_s;
                  req_tgt_q   <= sel_tgt_s;
                  rec_valid_q <= 1'b1;
                  state_q     <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (bus.rec_ack) begin
                  rec_valid_q <= 1'b0;
                  state_q     <= ST_WAIT;
                  if (sel_older_req_s) begin
                     pend_valid_q <= 1'b1;
                     pend_ptr_q   <= sel_ptr_s;
                     pend_tgt_q   <= sel_tgt_s;
                  end
               end else if (sel_older_req_s) begin
                  req_ptr_q <= sel_ptr_s;
                  req_tgt_q <= sel_tgt_s;
               end
            end
            ST_WAIT: begin
               if (bus.rec_done) begin
                  pend_valid_q <= 1'b0;
                  if (sel_keep_s) begin
                     req_ptr_q   <= sel_ptr_s;
                     req_tgt_q   <= sel_tgt_s;
                     rec_valid_q <= 1'b1;
                     state_q     <= ST_REQ;
                  end else if (pend_valid_q) begin
                     req_ptr_q   <= pend_ptr_q;
                     req_tgt_q   <= pend_tgt_q;
                     rec_valid_q <= 1'b1;
                     state_q     <= ST_REQ;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else if (sel_keep_s) begin
                  pend_valid_q <= 1'b1;
                  pend_ptr_q   <= sel_ptr_s;
                  pend_tgt_q   <= sel_tgt_s;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               rec_valid_q  <= 1'b0;
               pend_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Pack each lane's result into an update entry.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         push_data_s[l] = '{pc: bus.br_pc[l], next: bus.br_next[l],
                            taken: bus.br_taken[l], is_cond: bus.br_is_cond[l],
                            ghist: bus.br_ghist[l]};
      end
   end

   br_update_fifo #(
      .LANES   (LANES),
      .DEPTH   (FIFO_DEPTH),
      .entry_t (br_update_entry_t)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (bus.br_valid),
      .push_data_i (push_data_s),
      .pop_i       (bus.upd_ready),
      .valid_o     (upd_valid_s),
      .data_o      (upd_entry_s),
      .stall_o     (stall_s)
   );

   assign bus.rec_valid  = rec_valid_q;
   assign bus.rec_al_ptr = req_ptr_q;
   assign bus.rec_target = req_tgt_q;
   assign bus.upd_valid  = upd_valid_s;
   assign bus.upd_entry  = upd_entry_s;
   assign bus.stall_req  = stall_s;

endmodule

// File: tb/tb_int_branch_resolve_unit.sv
// Self-checking bench: table-driven age-select vectors, directed recovery and
// FIFO sequences, and random traffic against a list-based reference model.
module tb_int_branch_resolve_unit;
   import int_branch_resolve_unit_pkg::*;

   localparam int LANES = 2;
   localparam int AW    = 6;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int_branch_resolve_unit_if #(.LANES(LANES), .AL_PTR_W(AW)) bus ();

   int_branch_resolve_unit #(.LANES(LANES), .AL_PTR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 = no request, 1 = requesting, 2 = recovering.
   int               m_mode;
   int               m_ptr;
   logic [31:0]      m_tgt;
   int               pend_ptr [$];
   logic [31:0]      pend_tgt [$];
   br_update_entry_t m_fifo [$];

   typedef struct {
      int          head;
      bit [1:0]    v;
      bit [1:0]    m;
      int          p0;
      int          p1;
      logic [31:0] n0;
      logic [31:0] n1;
      int          exp_ptr;
      logic [31:0] exp_tgt;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int age(input int p, input int h);
      return (p + 64 - h) % 64;
   endfunction

   task automatic model_reset();
      m_mode = 0;
      m_ptr  = 0;
      m_tgt  = 32'd0;
      pend_ptr.delete();
      pend_tgt.delete();
      m_fifo.delete();
   endtask

   task automatic model_step();
      int          h, sp, best;
      bit          sv;
      logic [31:0] st;
      h  = int'(bus.al_head);
      sv = 1'b0; sp = 0; st = 32'd0;
      for (int l = 0; l < LANES; l++) begin
         if (bus.br_valid[l] && bus.br_mispred[l] &&
             (!sv || age(int'(bus.br_al_ptr[l]), h) < age(sp, h))) begin
            sv = 1'b1; sp = int'(bus.br_al_ptr[l]); st = bus.br_next[l];
         end
      end
      if (m_mode == 0) begin
         if (sv) begin m_mode = 1; m_ptr = sp; m_tgt = st; end
      end else if (m_mode == 1) begin
         if (bus.rec_ack) begin
            m_mode = 2;
            if (sv && age(sp, h) < age(m_ptr, h)) begin pend_ptr.push_back(sp); pend_tgt.push_back(st); end
         end else if (sv && age(sp, h) < age(m_ptr, h)) begin
            m_ptr = sp; m_tgt = st;
         end
      end else begin
         if (sv && age(sp, h) < age(m_ptr, h)) begin pend_ptr.push_back(sp); pend_tgt.push_back(st); end
         if (bus.rec_done) begin
            if (pend_ptr.size() > 0) begin
               best = 0;
               foreach (pend_ptr[i]) if (age(pend_ptr[i], h) < age(pend_ptr[best], h)) best = i;
               m_mode = 1; m_ptr = pend_ptr[best]; m_tgt = pend_tgt[best];
            end else begin
               m_mode = 0;
            end
            pend_ptr.delete();
            pend_tgt.delete();
         end
      end
      if (m_fifo.size() > 0 && bus.upd_ready) void'(m_fifo.pop_front());
      for (int l = 0; l < LANES; l++) begin
         if (bus.br_valid[l])
            m_fifo.push_back('{pc: bus.br_pc[l], next: bus.br_next[l], taken: bus.br_taken[l],
                               is_cond: bus.br_is_cond[l], ghist: bus.br_ghist[l]});
      end
   endtask

   task automatic check_model();
      chk("rec_valid", 64'(bus.rec_valid), 64'(m_mode == 1));
      if (m_mode == 1) begin
         chk("rec_al_ptr", 64'(bus.rec_al_ptr), 64'(m_ptr));
         chk("rec_target", 64'(bus.rec_target), 64'(m_tgt));
      end
      chk("upd_valid", 64'(bus.upd_valid), 64'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) begin
         chk("upd_pc", 64'(bus.upd_entry.pc), 64'(m_fifo[0].pc));
         chk("upd_next", 64'(bus.upd_entry.next), 64'(m_fifo[0].next));
         chk("upd_bits", 64'({bus.upd_entry.taken, bus.upd_entry.is_cond, bus.upd_entry.ghist}),
             64'({m_fifo[0].taken, m_fifo[0].is_cond, m_fifo[0].ghist}));
      end
      chk("stall_req", 64'(bus.stall_req), 64'(m_fifo.size() > DEPTH - LANES));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic idle_inputs();
      bus.br_valid = '0; bus.br_mispred = '0; bus.br_al_ptr = '0; bus.br_pc = '0;
      bus.br_next = '0; bus.br_taken = '0; bus.br_is_cond = '0; bus.br_ghist = '0;
      bus.rec_ack = 1'b0; bus.rec_done = 1'b0;
   endtask

   task automatic drive_lane(input int l, input bit v, input bit m, input int ptr,
                             input logic [31:0] pc, input logic [31:0] nxt);
      bus.br_valid[l]   = v;
      bus.br_mispred[l] = m;
      bus.br_al_ptr[l]  = AW'(ptr);
      bus.br_pc[l]      = pc;
      bus.br_next[l]    = nxt;
      bus.br_taken[l]   = (nxt != pc + 32'd4);
      bus.br_is_cond[l] = pc[2];
      bus.br_ghist[l]   = pc[11:2];
   endtask

   task automatic finish_recovery();
      idle_inputs(); bus.rec_ack = 1'b1; step();
      idle_inputs(); bus.rec_done = 1'b1; step();
      idle_inputs();
   endtask

   vec_t vecs [6];

   initial begin
      vecs[0] = '{60, 2'b11, 2'b11,  2, 62, 32'h100, 32'h200, 62, 32'h200};
      vecs[1] = '{ 0, 2'b11, 2'b01,  5,  3, 32'h110, 32'h210,  5, 32'h110};
      vecs[2] = '{ 0, 2'b10, 2'b11,  1,  9, 32'h120, 32'h220,  9, 32'h220};
      vecs[3] = '{10, 2'b11, 2'b11,  9, 12, 32'h130, 32'h230, 12, 32'h230};
      vecs[4] = '{ 0, 2'b11, 2'b11,  7,  7, 32'h140, 32'h240,  7, 32'h140};
      vecs[5] = '{32, 2'b11, 2'b11, 40, 33, 32'h150, 32'h250, 33, 32'h250};

      idle_inputs();
      bus.al_head = '0;
      bus.upd_ready = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Reset state with no input
      for (int i = 0; i < 10; i++) begin
         step();
         chk("rst_rec_valid", 64'(bus.rec_valid), 64'd0);
         chk("rst_upd_valid", 64'(bus.upd_valid), 64'd0);
         chk("rst_stall", 64'(bus.stall_req), 64'd0);
      end

      // Age-select vectors
      for (int i = 0; i < 6; i++) begin
         idle_inputs();
         bus.al_head = AW'(vecs[i].head);
         drive_lane(0, vecs[i].v[0], vecs[i].m[0], vecs[i].p0, 32'h1000 + 32'(i * 16), vecs[i].n0);
         drive_lane(1, vecs[i].v[1], vecs[i].m[1], vecs[i].p1, 32'h1004 + 32'(i * 16), vecs[i].n1);
         step();
         chk("vec_rec_valid", 64'(bus.rec_valid), 64'd1);
         chk("vec_rec_ptr", 64'(bus.rec_al_ptr), 64'(vecs[i].exp_ptr));
         chk("vec_rec_target", 64'(bus.rec_target), 64'(vecs[i].exp_tgt));
         finish_recovery();
      end

      // Older mispredict replaces held request, younger is dropped
      idle_inputs(); bus.al_head = '0;
      drive_lane(0, 1'b1, 1'b1, 10, 32'h3000, 32'h3100); step();
      idle_inputs(); drive_lane(0, 1'b1, 1'b1, 5, 32'h3010, 32'h3200); step();
      chk("replace_valid", 64'(bus.rec_valid), 64'd1);
      chk("replace_ptr", 64'(bus.rec_al_ptr), 64'd5);
      idle_inputs(); drive_lane(0, 1'b1, 1'b1, 20, 32'h3020, 32'h3300); step();
      chk("keep_valid", 64'(bus.rec_valid), 64'd1);
      chk("keep_ptr", 64'(bus.rec_al_ptr), 64'd5);
      chk("keep_target", 64'(bus.rec_target), 64'h3200);
      finish_recovery();

      // Ack with same-cycle older mispredict goes to pending
      drive_lane(0, 1'b1, 1'b1, 10, 32'h4000, 32'h4100); step();
      idle_inputs(); bus.rec_ack = 1'b1; drive_lane(1, 1'b1, 1'b1, 4, 32'h4010, 32'h4400); step();
      chk("ack_ptr_unchanged_valid", 64'(bus.rec_valid), 64'd0);
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         step();
         chk("wait_rec_valid", 64'(bus.rec_valid), 64'd0);
      end
      bus.rec_done = 1'b1; step();
      chk("pend_rec_valid", 64'(bus.rec_valid), 64'd1);
      chk("pend_rec_ptr", 64'(bus.rec_al_ptr), 64'd4);
      chk("pend_rec_target", 64'(bus.rec_target), 64'h4400);
      finish_recovery();

      // FIFO fill with no consumer, then ordered drain
      bus.upd_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         idle_inputs();
         drive_lane(0, 1'b1, 1'b0, 0, 32'h2000 + 32'(c * 8), 32'h2004 + 32'(c * 8));
         drive_lane(1, 1'b1, 1'b0, 1, 32'h2004 + 32'(c * 8), 32'h5000);
         step();
         chk("fill_stall", 64'(bus.stall_req), 64'(c == 3));
      end
      idle_inputs(); bus.upd_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk("drain_pc", 64'(bus.upd_entry.pc), 64'(32'h2000 + 32'(k * 4)));
         step();
      end
      chk("drain_empty", 64'(bus.upd_valid), 64'd0);

      // Asynchronous reset while recovering with five FIFO entries
      bus.upd_ready = 1'b0;
      drive_lane(0, 1'b1, 1'b1, 7, 32'h6000, 32'h6100);
      drive_lane(1, 1'b1, 1'b0, 8, 32'h6004, 32'h6008); step();
      idle_inputs(); bus.rec_ack = 1'b1;
      drive_lane(0, 1'b1, 1'b0, 9, 32'h6010, 32'h6014);
      drive_lane(1, 1'b1, 1'b0, 10, 32'h6018, 32'h601c); step();
      idle_inputs(); drive_lane(0, 1'b1, 1'b0, 11, 32'h6020, 32'h6024); step();
      chk("pre_rst_upd_valid", 64'(bus.upd_valid), 64'd1);
      idle_inputs();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_rec_valid", 64'(bus.rec_valid), 64'd0);
      chk("arst_upd_valid", 64'(bus.upd_valid), 64'd0);
      chk("arst_stall", 64'(bus.stall_req), 64'd0);
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      bus.upd_ready = 1'b1;
      bus.rec_done = 1'b1; step();
      idle_inputs();
      for (int i = 0; i < 3; i++) step();

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         int p0;
         idle_inputs();
         if (m_mode == 0 && pend_ptr.size() == 0 && $urandom_range(0, 7) == 0)
            bus.al_head = AW'($urandom_range(0, 63));
         bus.upd_ready = ($urandom_range(0, 2) != 0);
         if (m_fifo.size() <= DEPTH - LANES) begin
            p0 = $urandom_range(0, 63);
            drive_lane(0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, p0, $urandom, $urandom);
            drive_lane(1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                       (p0 + 1 + $urandom_range(0, 62)) % 64, $urandom, $urandom);
         end
         bus.rec_ack  = ($urandom_range(0, 2) == 0);
         bus.rec_done = ($urandom_range(0, 4) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
